// File: rtl/tx_pkg.sv
// Shared types and default constants for the CDL transmit packet sequencer.
package tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    SYNC,
    DATA,
    EOP,
    IDLE_BIT,
    DONE
  } tx_state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'h80;
  localparam int         DEFAULT_MAX_BYTES = 64;
  localparam int         DEFAULT_EOP_BITS  = 2;

endpackage

// File: rtl/tx_sequencer.sv
// Packet-level controller for the transmit path: SYNC byte, N data bytes from
// the FIFO, EOP for EOP_BITS bit times, one idle bit, then a done pulse.
module tx_sequencer
  import tx_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE,
  parameter int         MAX_BYTES = DEFAULT_MAX_BYTES,
  parameter int         EOP_BITS  = DEFAULT_EOP_BITS,
  parameter int         LEN_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tx_start,
  input  logic [LEN_W-1:0] tx_packet_len,
  input  logic             fifo_empty,
  input  logic [7:0]       fifo_rdata,
  output logic             fifo_pop,
  input  logic             strobe,
  input  logic             byte_transmitted,
  output logic             timer_enable,
  output logic             timer_clear,
  output logic             tx_transfer_active,
  output logic             load_byte,
  output logic [7:0]       load_data,
  output logic             eop_drive,
  output logic             tx_busy,
  output logic             tx_done,
  output logic             tx_error
);

  localparam int CNT_W = $clog2(EOP_BITS + 1);
  localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_BYTES);
  localparam logic [CNT_W-1:0] EOP_LAST = CNT_W'(EOP_BITS - 1);

  tx_state_t        state_reg;
  logic [LEN_W-1:0] remaining_reg;
  logic [CNT_W-1:0] eop_cnt_reg;
  logic             len_err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      remaining_reg <= '0;
      eop_cnt_reg   <= '0;
      len_err_reg   <= 1'b0;
    end else begin
      len_err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (tx_start) begin
            if (tx_packet_len > MAX_LEN) begin
              len_err_reg <= 1'b1;
            end else begin
              remaining_reg <= tx_packet_len;
              state_reg     <= START;
            end
          end
        end
        START: begin
          eop_cnt_reg <= '0;
          state_reg   <= SYNC;
        end
        SYNC, DATA: begin
          // A strobe coinciding with the byte boundary is irrelevant here.
          if (byte_transmitted) begin
            if (remaining_reg != '0) begin
              if (!fifo_empty) begin
                remaining_reg <= remaining_reg - 1'b1;
                state_reg     <= DATA;
              end else begin
                remaining_reg <= '0;
                state_reg     <= EOP;
              end
            end else begin
              state_reg <= EOP;
            end
          end
        end
        EOP: begin
          if (strobe) begin
            if (eop_cnt_reg == EOP_LAST) begin
              eop_cnt_reg <= '0;
              state_reg   <= IDLE_BIT;
            end else begin
              eop_cnt_reg <= eop_cnt_reg + 1'b1;
            end
          end
        end
        IDLE_BIT: begin
          if (strobe) state_reg <= DONE;
        end
        DONE: state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Byte reload is Mealy so the shift register never idles between bytes.
  always_comb begin
    fifo_pop           = 1'b0;
    load_byte          = 1'b0;
    load_data          = 8'h00;
    timer_enable       = 1'b0;
    timer_clear        = 1'b0;
    tx_transfer_active = 1'b0;
    eop_drive          = 1'b0;
    tx_busy            = (state_reg != IDLE);
    tx_done            = 1'b0;
    tx_error           = len_err_reg;
    case (state_reg)
      START: begin
        timer_clear = 1'b1;
        load_byte   = 1'b1;
        load_data   = SYNC_BYTE;
      end
      SYNC, DATA: begin
        timer_enable       = 1'b1;
        tx_transfer_active = 1'b1;
        if (byte_transmitted && (remaining_reg != '0)) begin
          if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            load_byte = 1'b1;
            load_data = fifo_rdata;
          end else begin
            tx_error = 1'b1;
          end
        end
      end
      EOP: begin
        eop_drive          = 1'b1;
        timer_enable       = 1'b1;
        tx_transfer_active = 1'b1;
      end
      IDLE_BIT: begin
        timer_enable       = 1'b1;
        tx_transfer_active = 1'b1;
      end
      DONE: begin
        tx_done     = 1'b1;
        timer_clear = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tx_sequencer.sv
// Self-checking bench for tx_sequencer: a behavioural bit/byte timer and FIFO
// drive the DUT; loaded bytes are checked against a scoreboard queue.
module tb_tx_sequencer;

  localparam int LEN_W = 7;

  logic             clk = 1'b0;
  logic             rst;
  logic             tx_start;
  logic [LEN_W-1:0] tx_packet_len;
  logic             fifo_empty;
  logic [7:0]       fifo_rdata;
  logic             fifo_pop;
  logic             strobe;
  logic             byte_transmitted;
  logic             timer_enable;
  logic             timer_clear;
  logic             tx_transfer_active;
  logic             load_byte;
  logic [7:0]       load_data;
  logic             eop_drive;
  logic             tx_busy;
  logic             tx_done;
  logic             tx_error;

  tx_sequencer dut (
    .clk                (clk),
    .rst                (rst),
    .tx_start           (tx_start),
    .tx_packet_len      (tx_packet_len),
    .fifo_empty         (fifo_empty),
    .fifo_rdata         (fifo_rdata),
    .fifo_pop           (fifo_pop),
    .strobe             (strobe),
    .byte_transmitted   (byte_transmitted),
    .timer_enable       (timer_enable),
    .timer_clear        (timer_clear),
    .tx_transfer_active (tx_transfer_active),
    .load_byte          (load_byte),
    .load_data          (load_data),
    .eop_drive          (eop_drive),
    .tx_busy            (tx_busy),
    .tx_done            (tx_done),
    .tx_error           (tx_error)
  );

  always #5 clk = ~clk;

  wire [16:0] all_outs = {fifo_pop, timer_enable, timer_clear, tx_transfer_active,
                          load_byte, eop_drive, tx_busy, tx_done, tx_error, load_data};

  typedef struct {
    int len;
    int nfifo;
    int pops;
    int err;
    int done;
    int eop;
    int te_first;
  } vec_t;

  vec_t     vecs[6];
  logic [7:0] fifo_q[$];
  logic [7:0] sb[$];

  int n_checks = 0;
  int n_pass   = 0;
  int ph, bits, cyc;
  int n_pops, n_err, n_done, n_eop, n_busy, n_te, first_te, err_cycle, err_bt;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic clear_stats();
    cyc = 0; n_pops = 0; n_err = 0; n_done = 0; n_eop = 0; n_busy = 0; n_te = 0;
    first_te = -1; err_cycle = -1; err_bt = -1;
  endtask

  task automatic fill_fifo(input int n);
    fifo_q.delete();
    for (int k = 0; k < n; k++) fifo_q.push_back(8'(8'hA1 + k * 8'h11));
  endtask

  // One clock: drive timer/FIFO inputs after the edge, then observe outputs.
  task automatic cycle();
    @(posedge clk);
    #1;
    cyc++;
    tx_start = 1'b0;
    if (timer_clear || rst) begin
      ph = 0; bits = 0; strobe = 1'b0; byte_transmitted = 1'b0;
    end else if (timer_enable) begin
      ph++;
      strobe = (ph % 2 == 0);
      if (strobe) bits++;
      byte_transmitted = strobe && (bits % 8 == 0);
    end else begin
      strobe = 1'b0; byte_transmitted = 1'b0;
    end
    fifo_empty = (fifo_q.size() == 0);
    fifo_rdata = fifo_empty ? 8'h00 : fifo_q[0];
    #1;
    if (fifo_pop) begin
      n_pops++;
      if (fifo_q.size() == 0) check("pop_while_empty", int'(fifo_empty), 0);
      else void'(fifo_q.pop_front());
    end
    if (load_byte) begin
      if (sb.size() == 0) check("unexpected_load", int'(load_data), -1);
      else check("load_data", int'(load_data), int'(sb.pop_front()));
    end
    if (tx_error) begin n_err++; err_cycle = cyc; err_bt = int'(byte_transmitted); end
    if (tx_done) n_done++;
    if (eop_drive && strobe) n_eop++;
    if (tx_busy) n_busy++;
    if (timer_enable) begin n_te++; if (first_te < 0) first_te = cyc; end
  endtask

  task automatic run_until_idle(input int max_cyc);
    int start = cyc;
    while (!(cyc - start >= 10 && !tx_busy) && (cyc - start < max_cyc)) cycle();
    if (cyc - start >= max_cyc) check("idle_timeout", int'(tx_busy), 0);
  endtask

  task automatic wait_pops(input int k);
    int start = cyc;
    while (n_pops < k && (cyc - start < 2000)) cycle();
    check("wait_pops", n_pops, k);
  endtask

  initial begin
    vecs[0] = '{3,  3,  3,  0, 1, 2, 2};   // normal A1,B2,C3
    vecs[1] = '{0,  2,  0,  0, 1, 2, 2};   // empty packet, FIFO untouched
    vecs[2] = '{2,  1,  1,  1, 1, 2, 2};   // underflow on 2nd data byte
    vecs[3] = '{65, 0,  0,  1, 0, 0, -1};  // length too large
    vecs[4] = '{1,  0,  0,  1, 1, 2, 2};   // underflow on 1st data byte
    vecs[5] = '{64, 64, 64, 0, 1, 2, 2};   // maximum length

    rst = 1'b1; tx_start = 1'b0; tx_packet_len = '0;
    fifo_empty = 1'b1; fifo_rdata = 8'h00; strobe = 1'b0; byte_transmitted = 1'b0;
    ph = 0; bits = 0;
    clear_stats();
    repeat (3) cycle();
    check("reset_outputs", int'(all_outs), 0);
    rst = 1'b0;
    cycle();

    for (int i = 0; i < 6; i++) begin
      fill_fifo(vecs[i].nfifo);
      sb.delete();
      if (vecs[i].len <= 64) sb.push_back(8'h80);
      for (int k = 0; k < vecs[i].pops; k++) sb.push_back(fifo_q[k]);
      clear_stats();
      tx_packet_len = LEN_W'(vecs[i].len);
      tx_start = 1'b1;
      run_until_idle(3000);
      check($sformatf("v%0d_pops", i), n_pops, vecs[i].pops);
      check($sformatf("v%0d_err", i), n_err, vecs[i].err);
      check($sformatf("v%0d_done", i), n_done, vecs[i].done);
      check($sformatf("v%0d_eop_strobes", i), n_eop, vecs[i].eop);
      check($sformatf("v%0d_first_te", i), first_te, vecs[i].te_first);
      check($sformatf("v%0d_sb_left", i), sb.size(), 0);
      check($sformatf("v%0d_fifo_left", i), fifo_q.size(), vecs[i].nfifo - vecs[i].pops);
      if (vecs[i].len > 64) begin
        check($sformatf("v%0d_err_cycle", i), err_cycle, 1);
        check($sformatf("v%0d_busy_cycles", i), n_busy, 0);
      end else if (vecs[i].err != 0) begin
        check($sformatf("v%0d_err_on_byte", i), err_bt, 1);
      end
      $display("vector %0d: len=%0d fifo=%0d pops=%0d err=%0d done=%0d eop=%0d",
               i, vecs[i].len, vecs[i].nfifo, n_pops, n_err, n_done, n_eop);
    end

    // Reset in the middle of a 4-byte packet.
    fill_fifo(4);
    sb.delete();
    sb.push_back(8'h80);
    for (int k = 0; k < 4; k++) sb.push_back(fifo_q[k]);
    clear_stats();
    tx_packet_len = LEN_W'(4);
    tx_start = 1'b1;
    wait_pops(2);
    rst = 1'b1;
    cycle();
    check("midreset_outputs", int'(all_outs), 0);
    rst = 1'b0;
    n_done = 0; n_err = 0; n_busy = 0; n_pops = 0;
    repeat (40) cycle();
    check("midreset_no_done", n_done, 0);
    check("midreset_no_err", n_err, 0);
    check("midreset_idle", n_busy, 0);
    check("midreset_no_pops", n_pops, 0);
    $display("midreset: done=%0d err=%0d busy_cycles=%0d", n_done, n_err, n_busy);

    // tx_start while DATA is running must be ignored.
    fill_fifo(5);
    sb.delete();
    sb.push_back(8'h80);
    for (int k = 0; k < 3; k++) sb.push_back(fifo_q[k]);
    clear_stats();
    tx_packet_len = LEN_W'(3);
    tx_start = 1'b1;
    wait_pops(1);
    tx_packet_len = LEN_W'(5);
    tx_start = 1'b1;
    run_until_idle(3000);
    check("ignore_start_pops", n_pops, 3);
    check("ignore_start_done", n_done, 1);
    check("ignore_start_err", n_err, 0);
    check("ignore_start_fifo_left", fifo_q.size(), 2);
    check("ignore_start_sb_left", sb.size(), 0);
    $display("ignore_start: pops=%0d done=%0d fifo_left=%0d", n_pops, n_done, fifo_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
